// File: rtl/counter_seq_arbiter.sv
// Round-robin sequencer that shares one 3-bit counter between NUM_REQ requesters.
// Optional build macro CTRL_SEEK_SHORTCUT_EN: SEEK to 0 / all-ones runs as CLR / SET.
module counter_seq_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_arg,
    input  logic [WIDTH-1:0]         cnt_count,
    output logic                     cnt_clr,
    output logic                     cnt_set,
    output logic                     cnt_load,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [WIDTH-1:0]         rsp_count,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_EXEC  = 3'd2,
        S_SEEK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_ROT  = 2'b10;
    localparam logic [1:0] OP_SEEK = 2'b11;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_ptr;
    logic [1:0]         r_id;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_arg;
    logic [WIDTH-1:0]   r_rep;
    logic               r_clr;
    logic               r_set;
    logic               r_load;

    logic               w_found;
    logic [1:0]         w_win;
    logic               w_in_valid;
    logic [1:0]         w_in_op;
    logic [WIDTH-1:0]   w_in_arg;
    logic [1:0]         w_cap_op;
    logic [1:0]         w_op;
    logic               w_seek_hit;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = 2'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Command fields of the requester selected in IDLE.
    always_comb begin
        w_in_valid = 1'b0;
        w_in_op    = OP_CLR;
        w_in_arg   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_id == 2'(i)) begin
                w_in_valid = req_valid[i];
                w_in_op    = req_op[2*i +: 2];
                w_in_arg   = req_arg[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        w_cap_op = w_in_op;
`ifdef CTRL_SEEK_SHORTCUT_EN
        if (w_in_op == OP_SEEK && w_in_arg == '0)
            w_cap_op = OP_CLR;
        else if (w_in_op == OP_SEEK && w_in_arg == {WIDTH{1'b1}})
            w_cap_op = OP_SET;
`endif
    end

    assign w_op       = (r_state == S_GRANT) ? w_cap_op : r_op;
    assign w_seek_hit = (r_state == S_SEEK) && (cnt_count == r_arg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_GRANT;
            S_GRANT: begin
                // A requester that withdrew before the handshake edge is simply dropped.
                if (!w_in_valid)
                    w_next = S_IDLE;
                else if (w_cap_op == OP_SEEK)
                    w_next = S_SEEK;
                else
                    w_next = S_EXEC;
            end
            S_EXEC:  if (r_op != OP_ROT || r_rep == '0) w_next = S_DONE;
            S_SEEK:  if (w_seek_hit) w_next = S_IDLE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= 2'd0;
            r_id   <= 2'd0;
            r_op   <= OP_CLR;
            r_arg  <= '0;
            r_rep  <= '0;
            r_clr  <= 1'b0;
            r_set  <= 1'b0;
            r_load <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found)
                r_id <= w_win;
            if (r_state == S_GRANT) begin
                r_op  <= w_cap_op;
                r_arg <= w_in_arg;
                r_rep <= w_in_arg;
            end else if (r_state == S_EXEC && r_rep != '0) begin
                r_rep <= r_rep - 1'b1;
            end
            if (rsp_valid)
                r_ptr <= (r_id == 2'(NUM_REQ - 1)) ? 2'd0 : r_id + 2'd1;
            // Controls are registered from the next state so they are high exactly in EXEC.
            r_clr  <= (w_next == S_EXEC) && (w_op == OP_CLR);
            r_set  <= (w_next == S_EXEC) && (w_op == OP_SET);
            r_load <= (w_next == S_EXEC) && (w_op == OP_ROT);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = (r_state == S_GRANT) && w_in_valid && (r_id == 2'(i));
        rsp_valid = (r_state == S_DONE) || w_seek_hit;
        rsp_id    = r_id;
        rsp_count = cnt_count;
        busy      = (r_state != S_IDLE);
        cnt_clr   = r_clr;
        cnt_set   = r_set;
        cnt_load  = r_load;
    end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench for counter_seq_arbiter with a behavioural 3-bit counter and a response scoreboard.
// Honours CTRL_SEEK_SHORTCUT_EN when the bundle is built with it.
module tb_counter_seq_arbiter;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_ROT  = 2'b10;
    localparam logic [1:0] OP_SEEK = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [3:0] req_op = '0;
    logic [5:0] req_arg = '0;
    logic [2:0] cnt;
    logic       cnt_clr, cnt_set, cnt_load;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [2:0] rsp_count;
    logic       busy;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] count;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    counter_seq_arbiter #(.NUM_REQ(2), .WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_arg(req_arg),
        .cnt_count(cnt),
        .cnt_clr(cnt_clr), .cnt_set(cnt_set), .cnt_load(cnt_load),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared counter the block drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         cnt <= 3'd0;
        else if (cnt_clr)  cnt <= 3'd0;
        else if (cnt_set)  cnt <= 3'd7;
        else if (cnt_load) cnt <= {cnt[1:0], cnt[2]};
        else               cnt <= cnt + 3'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            chk("rsp_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_count", 32'(rsp_count), 32'(mon_e.count));
            end
        end
    end

    function automatic logic [1:0] eff_op(input logic [1:0] op, input logic [2:0] arg);
        eff_op = op;
`ifdef CTRL_SEEK_SHORTCUT_EN
        if (op == OP_SEEK && arg == 3'd0) eff_op = OP_CLR;
        if (op == OP_SEEK && arg == 3'd7) eff_op = OP_SET;
`endif
    endfunction

    // Expected count from the counter value g seen during GRANT.
    function automatic logic [2:0] exp_count(input logic [1:0] op, input logic [2:0] arg,
                                             input logic [2:0] g);
        logic [2:0] v;
        case (op)
            OP_CLR: v = 3'd0;
            OP_SET: v = 3'd7;
            OP_ROT: begin
                v = g + 3'd1;
                for (int i = 0; i <= int'(arg); i++) v = {v[1:0], v[2]};
            end
            default: v = arg;
        endcase
        exp_count = v;
    endfunction

    task automatic drive(input int id, input logic v, input logic [1:0] op, input logic [2:0] arg);
        req_valid[id]       = v;
        req_op[2*id +: 2]   = op;
        req_arg[3*id +: 3]  = arg;
    endtask

    task automatic wait_idle(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        chk(tag, 32'(got), 1);
    endtask

    // One command end to end: handshake, control pulse counts, latency, scoreboard push.
    task automatic do_cmd(input string tag, input int id, input logic [1:0] op, input logic [2:0] arg);
        logic       got = 1'b0;
        logic [1:0] eop;
        logic [2:0] g, d;
        int lat = 0, nclr = 0, nset = 0, nload = 0, elat;
        rsp_t e;
        drive(id, 1'b1, op, arg);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        chk({tag, "_ready"}, 32'(got), 1);
        if (got) begin
            g   = cnt;
            eop = eff_op(op, arg);
            e.id    = 2'(id);
            e.count = exp_count(eop, arg, g);
            sb_q.push_back(e);
            d = arg - g - 3'd1;
            elat = (eop == OP_SEEK) ? int'(d) + 1 : (eop == OP_ROT) ? int'(arg) + 2 : 2;
            @(posedge clk);
            #1 req_valid[id] = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                lat++;
                nclr  += int'(cnt_clr);
                nset  += int'(cnt_set);
                nload += int'(cnt_load);
                if (rsp_valid) got = 1'b1;
            end
            chk({tag, "_rsp_seen"}, 32'(got), 1);
            chk({tag, "_latency"}, 32'(lat), 32'(elat));
            chk({tag, "_clr_cycles"}, 32'(nclr), (eop == OP_CLR) ? 1 : 0);
            chk({tag, "_set_cycles"}, 32'(nset), (eop == OP_SET) ? 1 : 0);
            chk({tag, "_load_cycles"}, 32'(nload), (eop == OP_ROT) ? int'(arg) + 1 : 0);
        end else begin
            req_valid[id] = 1'b0;
        end
    endtask

    // Both requesters raise the same simple (non-ROT) command; check grant order.
    task automatic do_pair(input string tag, input logic [1:0] op, input logic [2:0] arg, input int first);
        rsp_t e;
        int   who;
        logic got;
        drive(0, 1'b1, op, arg);
        drive(1, 1'b1, op, arg);
        for (int k = 0; k < 2; k++) begin
            who = (k == 0) ? first : 1 - first;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) got = 1'b1;
            end
            chk({tag, "_grant"}, 32'(req_ready), 32'(1 << who));
            e.id    = 2'(who);
            e.count = exp_count(eff_op(op, arg), arg, 3'd0);
            sb_q.push_back(e);
            @(posedge clk);
            #1 req_valid[who] = 1'b0;
            @(negedge clk);
            wait_idle({tag, "_done"});
        end
        req_valid = 2'b00;
    endtask

    initial begin
        logic got;
        int   nload;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy, cnt_clr, cnt_set, cnt_load, rsp_valid, rsp_id, req_ready}), 0);
        reset = 1'b0;

        // Idle: counter free-runs through a wrap with nothing driven.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", 32'({busy, cnt_clr, cnt_set, cnt_load, rsp_valid, req_ready}), 0);
        end

        do_cmd("set0", 0, OP_SET, 3'd0);

        // Start the rotate so the first load cycle sees 3'b011.
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cnt == 3'd1 && !busy) got = 1'b1;
        end
        chk("rot_align", 32'(got), 1);
        do_cmd("rot1", 1, OP_ROT, 3'd1);
        @(negedge clk);

        do_pair("seek4_pair", OP_SEEK, 3'd4, 0);
        do_pair("clr_pair", OP_CLR, 3'd0, 0);

        do_cmd("seek0", 1, OP_SEEK, 3'd0);
        @(negedge clk);
        do_cmd("seek7", 0, OP_SEEK, 3'd7);
        @(negedge clk);

        // Pointer now 1; abort a long rotate and confirm reset returns it to 0.
        do_cmd("set_pre_abort", 0, OP_SET, 3'd0);
        @(negedge clk);
        drive(1, 1'b1, OP_ROT, 3'd7);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        chk("abort_ready", 32'(got), 1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        nload = 0;
        for (int i = 0; i < 20 && nload < 3; i++) begin
            @(negedge clk);
            if (cnt_load) nload++;
        end
        chk("abort_loads_reached", 32'(nload), 3);
        reset = 1'b1;
        #1 chk("abort_outputs", 32'({busy, cnt_clr, cnt_set, cnt_load, rsp_valid, req_ready}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 32'(sb_q.size()), 0);
        do_pair("post_reset_pair", OP_CLR, 3'd0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_seq_arbiter.md
Name: counter_seq_arbiter

Overview:
- Shares one free-running 3-bit counter (async clear, set-to-7, rotate-left, otherwise +1 per cycle) between NUM_REQ requesters.
- Each requester submits a command (CLR, SET, ROT burst, SEEK to value) with a valid/ready handshake.
- Round-robin arbitration picks the next requester; the block sequences the counter's control pins and returns a one-cycle response with the resulting count.
- Sits between requester logic and the counter instance in the counter subsystem.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- WIDTH, 3, counter width; the command length and target fields use the same width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot acceptance pulse, one cycle wide.
- req_op  in  2*NUM_REQ  opcode per requester, slice i = [2i+1:2i]: 00 CLR, 01 SET, 10 ROT, 11 SEEK.
- req_arg  in  WIDTH*NUM_REQ  per-requester argument: ROT repeat count minus 1, or SEEK target.
- cnt_count  in  WIDTH  current counter value.
- cnt_clr  out  1  registered, drives the counter's clear input.
- cnt_set  out  1  registered, drives the counter's set input.
- cnt_load  out  1  registered, drives the counter's rotate/load input.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  2  index of the requester being answered.
- rsp_count  out  WIDTH  equals cnt_count in the rsp_valid cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, RR pointer 0, cnt_clr/cnt_set/cnt_load 0, req_ready 0, rsp_valid 0, rsp_id 0, busy 0.
- Reset asserted mid-command aborts the command. No response is issued and no pending request is accepted.
- Counter free-runs (+1 per cycle) whenever no control is driven. This is legal and expected.
- States: IDLE, GRANT, EXEC, SEEK, DONE.
- IDLE -> GRANT when any req_valid is high.
  - Winner is the first valid index at or after the RR pointer, wrapping modulo NUM_REQ.
- GRANT (one cycle):
  - req_ready[winner]=1.
  - Capture op, arg and id.
  - Load the repeat counter with arg.
  - Go to EXEC for CLR/SET/ROT, SEEK for SEEK.
- Requesters hold valid/op/arg stable until ready is seen. Valid dropped before ready is allowed; the command is then not executed.
- EXEC:
  - CLR drives cnt_clr=1 for exactly one cycle, then DONE.
  - SET drives cnt_set=1 for exactly one cycle, then DONE.
  - ROT drives cnt_load=1 for arg+1 consecutive cycles (1..8), then DONE.
- Control outputs are flop outputs: high during the EXEC cycles only, zero in every other state.
- DONE (one cycle):
  - rsp_valid=1, rsp_id=id, rsp_count=cnt_count. This is the settled result of the last control cycle.
  - RR pointer <= id+1 modulo NUM_REQ.
  - -> IDLE.
- SEEK:
  - No controls driven; the counter free-runs.
  - In the first cycle where cnt_count==target: rsp_valid=1, rsp_id=id, rsp_count=target, RR pointer updated, -> IDLE.
  - Bound: match within 2^WIDTH cycles.
- Turnaround: minimum of one IDLE cycle between commands. Back-to-back requests from the same requester are served only after the other valid requesters (fairness).
- Simultaneous valid requests: only the winner gets ready. The others wait with valid held.
- busy=1 from GRANT through DONE/SEEK completion.

Optional Feature:
- Macro: CTRL_SEEK_SHORTCUT_EN.
- Defined:
  - SEEK with target 0 is executed as CLR.
  - SEEK with target 2^WIDTH-1 is executed as SET.
  - Both go through EXEC/DONE: 3-cycle completion.
- Not defined: every SEEK waits in the SEEK state for a natural match.

Test Plan:
- Reset then idle, counter from 0 -> busy=0, all ctrl outputs 0, cnt_count wraps 7->0 freely, no rsp.
- Req0 SET -> ready0 in GRANT, cnt_set=1 one cycle, DONE: rsp_valid=1, rsp_id=0, rsp_count=7.
- Counter 3'b011, req1 ROT arg=1 -> cnt_load high 2 cycles, count 011->110->101, rsp_count=5, rsp_id=1.
- Req0 and req1 valid together, pointer 0, both SEEK target=4 -> req0 served first, then req1. Each rsp_count=4; pointer ends at 0.
- Req1 SEEK target=0, with and without CTRL_SEEK_SHORTCUT_EN -> defined: cnt_clr pulse, rsp 2 cycles after GRANT. Undefined: rsp when counter naturally reaches 0.
- Reset asserted during ROT arg=7 at third load cycle -> outputs 0 immediately, no rsp, next request served from pointer 0.
